// File: rtl/alarm_seq_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : alarm_seq_ctrl
// Brief    : Alarm sequencer that arms, rings, snoozes and auto-silences the
//            buzzer. Optional macro ALARM_BEEP_EN gives a 1 s on / 1 s off buzz.
// Revision : 1.0 - initial release
// =============================================================================
module alarm_seq_ctrl #(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tick,
  input  logic                              alarm_on,
  input  logic                              match,
  input  logic                              snooze_btn,
  input  logic                              stop_btn,
  output logic                              buzz,
  output logic                              ringing,
  output logic                              snoozing,
  output logic [$clog2(SNOOZE_SEC+1)-1:0]   snz_left,
  output logic [$clog2(MAX_SNOOZE+1)-1:0]   snz_used,
  output logic                              missed
);

  localparam int c_snz_w  = $clog2(SNOOZE_SEC+1);
  localparam int c_used_w = $clog2(MAX_SNOOZE+1);
  localparam int c_ring_w = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  localparam logic [c_snz_w-1:0]  c_snz_init  = c_snz_w'(SNOOZE_SEC);
  localparam logic [c_snz_w-1:0]  c_snz_one   = c_snz_w'(1);
  localparam logic [c_ring_w-1:0] c_ring_last = c_ring_w'(RING_SEC-1);
  localparam logic [c_used_w-1:0] c_used_max  = c_used_w'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_match_q, r_snooze_q, r_stop_q;
  logic [c_ring_w-1:0]   r_ring_cnt, w_ring_cnt_nxt;
  logic [c_snz_w-1:0]    r_snz_left, w_snz_left_nxt;
  logic [c_used_w-1:0]   r_snz_used, w_snz_used_nxt;
  logic                  r_missed, w_missed_nxt;

  logic w_match_rise, w_snz_press, w_stop_press;

  assign w_match_rise = match      & ~r_match_q;
  assign w_snz_press  = snooze_btn & ~r_snooze_q;
  assign w_stop_press = stop_btn   & ~r_stop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_OFF;
      r_match_q  <= 1'b0;
      r_snooze_q <= 1'b0;
      r_stop_q   <= 1'b0;
      r_ring_cnt <= '0;
      r_snz_left <= '0;
      r_snz_used <= '0;
      r_missed   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_match_q  <= match;
      r_snooze_q <= snooze_btn;
      r_stop_q   <= stop_btn;
      r_ring_cnt <= w_ring_cnt_nxt;
      r_snz_left <= w_snz_left_nxt;
      r_snz_used <= w_snz_used_nxt;
      r_missed   <= w_missed_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ring_cnt_nxt = r_ring_cnt;
    w_snz_left_nxt = r_snz_left;
    w_snz_used_nxt = r_snz_used;
    w_missed_nxt   = r_missed;

    if (!alarm_on) begin
      w_state_nxt    = S_OFF;
      w_ring_cnt_nxt = '0;
      w_snz_left_nxt = '0;
      w_snz_used_nxt = '0;
      w_missed_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_OFF: w_state_nxt = S_ARMED;

        S_ARMED: begin
          if (w_stop_press) w_missed_nxt = 1'b0;
          if (w_match_rise) begin
            w_state_nxt    = S_RINGING;
            w_ring_cnt_nxt = '0;
            w_snz_used_nxt = '0;
          end
        end

        S_RINGING: begin
          // An exhausted snooze press falls through so the tick still counts
          if (w_stop_press) begin
            w_state_nxt    = S_ARMED;
            w_missed_nxt   = 1'b0;
            w_ring_cnt_nxt = '0;
          end else if (w_snz_press && (r_snz_used < c_used_max)) begin
            w_state_nxt    = S_SNOOZE;
            w_snz_left_nxt = c_snz_init;
            w_snz_used_nxt = r_snz_used + 1'b1;
            w_ring_cnt_nxt = '0;
          end else if (tick) begin
            if (r_ring_cnt == c_ring_last) begin
              w_state_nxt    = S_ARMED;
              w_missed_nxt   = 1'b1;
              w_ring_cnt_nxt = '0;
            end else begin
              w_ring_cnt_nxt = r_ring_cnt + 1'b1;
            end
          end
        end

        S_SNOOZE: begin
          if (w_stop_press) begin
            w_state_nxt    = S_ARMED;
            w_snz_left_nxt = '0;
          end else if (tick) begin
            if (r_snz_left == c_snz_one) begin
              w_state_nxt    = S_RINGING;
              w_ring_cnt_nxt = '0;
              w_snz_left_nxt = '0;
            end else begin
              w_snz_left_nxt = r_snz_left - 1'b1;
            end
          end
        end

        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  assign ringing  = (r_state == S_RINGING);
  assign snoozing = (r_state == S_SNOOZE);
  assign snz_left = r_snz_left;
  assign snz_used = r_snz_used;
  assign missed   = r_missed;

`ifdef ALARM_BEEP_EN
  logic r_beep_phase, w_beep_nxt;

  // Phase restarts high on each ring entry and flips every tick while ringing
  always_comb begin
    w_beep_nxt = 1'b0;
    if (w_state_nxt == S_RINGING) begin
      if (r_state != S_RINGING) w_beep_nxt = 1'b1;
      else if (tick)            w_beep_nxt = ~r_beep_phase;
      else                      w_beep_nxt = r_beep_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_beep_phase <= 1'b0;
    else     r_beep_phase <= w_beep_nxt;
  end

  assign buzz = ringing & r_beep_phase;
`else
  assign buzz = ringing;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_seq_ctrl.sv
`default_nettype none
// Self-checking bench for alarm_seq_ctrl: directed scenarios plus random
// stimulus, all compared against an event-level reference model.
module tb_alarm_seq_ctrl;

  localparam int SNOOZE_SEC = 3;
  localparam int RING_SEC   = 4;
  localparam int MAX_SNOOZE = 2;
  localparam int SW = $clog2(SNOOZE_SEC+1);
  localparam int UW = $clog2(MAX_SNOOZE+1);

  localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3;

  logic clk = 1'b0;
  logic rst, tick, alarm_on, match, snooze_btn, stop_btn;
  logic buzz, ringing, snoozing, missed;
  logic [SW-1:0] snz_left;
  logic [UW-1:0] snz_used;

  always #5 clk = ~clk;

  alarm_seq_ctrl #(
    .SNOOZE_SEC(SNOOZE_SEC), .RING_SEC(RING_SEC), .MAX_SNOOZE(MAX_SNOOZE)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .alarm_on(alarm_on), .match(match),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn), .buzz(buzz),
    .ringing(ringing), .snoozing(snoozing), .snz_left(snz_left),
    .snz_used(snz_used), .missed(missed)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: mode plus elapsed/remaining tick counts
  int m_mode = M_OFF, m_elapsed = 0, m_left = 0, m_used = 0;
  bit m_missed = 0, m_beep = 0;
  bit p_match = 0, p_snz = 0, p_stop = 0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic mdl(input bit r, input bit on, input bit m, input bit sb, input bit st, input bit tk);
    bit rise, snz, stp;
    if (r) begin
      m_mode = M_OFF; m_elapsed = 0; m_left = 0; m_used = 0;
      m_missed = 0; m_beep = 0; p_match = 0; p_snz = 0; p_stop = 0;
      return;
    end
    rise = m && !p_match; snz = sb && !p_snz; stp = st && !p_stop;
    p_match = m; p_snz = sb; p_stop = st;
    if (!on) begin
      m_mode = M_OFF; m_elapsed = 0; m_left = 0; m_used = 0; m_missed = 0;
      return;
    end
    if (m_mode == M_OFF) begin
      m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (stp) m_missed = 0;
      if (rise) begin m_mode = M_RING; m_elapsed = 0; m_used = 0; m_beep = 1; end
    end else if (m_mode == M_RING) begin
      if (stp) begin
        m_mode = M_ARMED; m_missed = 0;
      end else if (snz && m_used < MAX_SNOOZE) begin
        m_mode = M_SNOOZE; m_left = SNOOZE_SEC; m_used++;
      end else if (tk) begin
        m_elapsed++;
        m_beep = !m_beep;
        if (m_elapsed == RING_SEC) begin m_mode = M_ARMED; m_missed = 1; m_elapsed = 0; end
      end
    end else begin
      if (stp) begin
        m_mode = M_ARMED; m_left = 0;
      end else if (tk) begin
        m_left--;
        if (m_left == 0) begin m_mode = M_RING; m_elapsed = 0; m_beep = 1; end
      end
    end
  endtask

  task automatic check_all();
    bit exp_buzz;
`ifdef ALARM_BEEP_EN
    exp_buzz = (m_mode == M_RING) && m_beep;
`else
    exp_buzz = (m_mode == M_RING);
`endif
    chk_val("ringing",  32'(ringing),  32'(m_mode == M_RING));
    chk_val("snoozing", 32'(snoozing), 32'(m_mode == M_SNOOZE));
    chk_val("buzz",     32'(buzz),     32'(exp_buzz));
    chk_val("snz_left", 32'(snz_left), 32'(m_left));
    chk_val("snz_used", 32'(snz_used), 32'(m_used));
    chk_val("missed",   32'(missed),   32'(m_missed));
  endtask

  // Ticks every 5 clocks; model advances on the same inputs the DUT samples
  task automatic step();
    bit r, a, m, sb, st, tk;
    tick = (cyc % 5 == 4);
    r = rst; a = alarm_on; m = match; sb = snooze_btn; st = stop_btn; tk = tick;
    @(posedge clk);
    mdl(r, a, m, sb, st, tk);
    cyc++;
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press_snz();
    snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
  endtask

  task automatic press_stop();
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
  endtask

  task automatic start_ring();
    match = 1'b0; step();
    match = 1'b1; step();
    chk_val("ring_on_rise", 32'(ringing), 32'd1);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; alarm_on = 1'b1; match = 1'b1;
    snooze_btn = 1'b1; stop_btn = 1'b1;
    steps(2);
    rst = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0; alarm_on = 1'b0;
    step();
    chk_val("reset_ringing", 32'(ringing), 32'd0);
    chk_val("reset_missed",  32'(missed),  32'd0);
    chk_val("reset_buzz",    32'(buzz),    32'd0);

    // Enabled mid-match minute: must stay silent until a fresh rise
    alarm_on = 1'b1;
    steps(8);
    chk_val("no_ring_mid_match", 32'(ringing), 32'd0);
    start_ring();
    chk_val("buzz_on_rise", 32'(buzz), 32'd1);
    press_stop();
    chk_val("stop_ringing", 32'(ringing), 32'd0);
    chk_val("stop_missed",  32'(missed),  32'd0);

    // Snooze cycle up to exhaustion
    start_ring();
    press_snz();
    chk_val("snz1_snoozing", 32'(snoozing), 32'd1);
    chk_val("snz1_left",     32'(snz_left), 32'd3);
    chk_val("snz1_used",     32'(snz_used), 32'd1);
    for (int i = 0; i < 40 && !ringing; i++) step();
    chk_val("snz1_ring_again", 32'(ringing), 32'd1);
    press_snz();
    chk_val("snz2_used", 32'(snz_used), 32'd2);
    for (int i = 0; i < 40 && !ringing; i++) step();
    chk_val("snz2_ring_again", 32'(ringing), 32'd1);
    step();
    press_snz();
    chk_val("snz3_ignored", 32'(ringing), 32'd1);
    press_stop();

    // Unattended timeout, then stop clears missed
    start_ring();
    for (int i = 0; i < 40 && ringing; i++) step();
    chk_val("timeout_ringing", 32'(ringing), 32'd0);
    chk_val("timeout_missed",  32'(missed),  32'd1);
    step();
    press_stop();
    chk_val("stop_clears_missed", 32'(missed), 32'd0);

    // Stop and snooze together: stop wins
    start_ring();
    stop_btn = 1'b1; snooze_btn = 1'b1; step();
    stop_btn = 1'b0; snooze_btn = 1'b0;
    chk_val("both_ringing",  32'(ringing),  32'd0);
    chk_val("both_snoozing", 32'(snoozing), 32'd0);
    step();

    // Switch off mid-snooze
    start_ring();
    press_snz();
    for (int i = 0; i < 40 && m_left != 2; i++) step();
    chk_val("snz_left_two", 32'(snz_left), 32'd2);
    alarm_on = 1'b0; step();
    chk_val("off_snoozing", 32'(snoozing), 32'd0);
    chk_val("off_left",     32'(snz_left), 32'd0);
    chk_val("off_used",     32'(snz_used), 32'd0);
    alarm_on = 1'b1; steps(2);

    // Reset while ringing, then a long ring window for the buzz pattern
    start_ring();
    rst = 1'b1; step(); rst = 1'b0;
    chk_val("rst_ringing", 32'(ringing), 32'd0);
    chk_val("rst_buzz",    32'(buzz),    32'd0);
    steps(2);
    start_ring();
    steps(18);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 299) == 0) alarm_on = ~alarm_on;
      if ($urandom_range(0, 29) == 0)  match = ~match;
      snooze_btn = ($urandom_range(0, 9) == 0);
      stop_btn   = ($urandom_range(0, 24) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alarm_seq_ctrl.md
Name: alarm_seq_ctrl

Overview:
- Sequences the alarm path of the clock: arms, rings, snoozes and auto-silences the buzzer from the time/alarm comparator result.
- Replaces the plain `Buzz = Alarmon && match` gating at the top level.
- Sits between the alarm comparator and the Buzz output.
- Shares the 1 Hz tick that advances the seconds counter.

Parameters:
- SNOOZE_SEC, 300, snooze length in ticks.
- RING_SEC, 60, ticks of continuous ringing before auto-silence.
- MAX_SNOOZE, 3, snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tick  in  1  one-cycle 1 Hz enable, same pulse that advances seconds.
- alarm_on  in  1  alarm enable switch (level).
- match  in  1  high while time hrs/min equal alarm hrs/min (level, whole minute).
- snooze_btn  in  1  snooze button (level, edge-detected internally).
- stop_btn  in  1  stop button (level, edge-detected internally).
- buzz  out  1  buzzer drive.
- ringing  out  1  state == RINGING.
- snoozing  out  1  state == SNOOZE.
- snz_left  out  $clog2(SNOOZE_SEC+1)  remaining snooze ticks; 0 outside SNOOZE.
- snz_used  out  $clog2(MAX_SNOOZE+1)  snoozes consumed this event.
- missed  out  1  sticky: an alarm event timed out unattended.

Behaviour:
- Reset (rst=1 at clk edge, wins over all inputs): state=OFF. Internal registers match_q, snooze_q, stop_q, ring_cnt, snz_left, snz_used, missed are all 0. All outputs 0.
- Edge detect:
  - match_q, snooze_q and stop_q are updated every cycle in every state.
  - match_rise = match & ~match_q; snz_press = snooze_btn & ~snooze_q; stop_press = stop_btn & ~stop_q.
  - Turning alarm_on on mid-match-minute does not ring.
- Moore machine. Outputs derive from registered state and counters. An event sampled at edge n is visible after edge n, i.e. 1-cycle latency.
- alarm_on=0 has highest priority after rst: next state OFF, ring_cnt=0, snz_left=0, snz_used=0, missed=0.
- OFF: alarm_on=1 -> ARMED.
- ARMED:
  - match_rise -> RINGING, with ring_cnt=0 and snz_used=0.
  - stop_press clears missed.
- RINGING (priority stop_press > snz_press > timeout):
  - stop_press -> ARMED, clears missed.
  - snz_press with snz_used<MAX_SNOOZE -> SNOOZE, snz_left=SNOOZE_SEC, snz_used+1.
  - snz_press with snz_used==MAX_SNOOZE is ignored.
  - tick with ring_cnt<RING_SEC-1: ring_cnt+1.
  - tick with ring_cnt==RING_SEC-1 -> ARMED, missed=1, ring_cnt=0.
- SNOOZE:
  - stop_press -> ARMED, snz_left=0.
  - snz_press is ignored.
  - tick: snz_left-1. A tick with snz_left==1 -> RINGING, ring_cnt=0, snz_left=0.
  - match_rise is ignored.
- A match_rise while RINGING or SNOOZE (next day) does not restart the event.
- ring_cnt width is $clog2(RING_SEC). Counters never wrap; they are bounded by the transitions above.
- buzz: 1 only in RINGING (see optional feature); 0 in all other states.

Optional Feature:
- Macro: ALARM_BEEP_EN.
- Defined:
  - A beep_phase register is set to 1 on every entry to RINGING and toggles on each tick while in RINGING.
  - buzz = ringing & beep_phase, giving 1 s on / 1 s off.
  - beep_phase is reset to 0.
- Undefined: buzz = ringing (continuous). No beep_phase register exists.

Test Plan:
- Use SNOOZE_SEC=3, RING_SEC=4, MAX_SNOOZE=2, tick every 5 clks.
- Reset: hold rst with all inputs high for 2 clks, release -> all outputs 0, state OFF. Then alarm_on=1 with match already 1 -> no ring until match falls and rises again.
- Basic ring/stop: alarm_on=1, match 0->1 at cycle n -> ringing=1 and buzz=1 from cycle n+1. stop_press -> ringing=0 next cycle, missed=0.
- Snooze cycle:
  - While ringing, snz_press -> snoozing=1, snz_left=3, snz_used=1.
  - After 3 ticks -> ringing=1 again.
  - Second snooze -> snz_used=2.
  - Third snz_press while ringing is ignored; ringing stays 1.
- Timeout: ring untouched for 4 ticks -> ringing=0 and missed=1 in the cycle after the 4th tick. Then stop_press in ARMED -> missed=0.
- Simultaneous / mid-operation:
  - stop_press and snz_press in the same cycle while ringing -> ARMED.
  - alarm_on=0 during SNOOZE with snz_left=2 -> OFF next cycle, snz_left=0, snz_used=0.
  - rst asserted during RINGING -> all outputs 0 next cycle.
- ALARM_BEEP_EN defined: during RINGING, buzz reads 1,0,1,0 across successive tick intervals, and ringing stays 1 throughout. Undefined: buzz is constant 1 over the same window.
